// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory request/response channel
// between the instruction cache and data cache, one transaction at a time.
module mem_arbiter #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int MASK_BITS = DATA_BITS/8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ic_req_valid,
   output logic                 ic_req_ready,
   input  logic [ADDR_BITS-1:0] ic_req_addr,
   input  logic                 ic_req_rw,
   input  logic                 ic_req_data_valid,
   output logic                 ic_req_data_ready,
   input  logic [DATA_BITS-1:0] ic_req_data_bits,
   input  logic [MASK_BITS-1:0] ic_req_data_mask,
   output logic                 ic_resp_valid,
   output logic [DATA_BITS-1:0] ic_resp_data,
   input  logic                 dc_req_valid,
   output logic                 dc_req_ready,
   input  logic [ADDR_BITS-1:0] dc_req_addr,
   input  logic                 dc_req_rw,
   input  logic                 dc_req_data_valid,
   output logic                 dc_req_data_ready,
   input  logic [DATA_BITS-1:0] dc_req_data_bits,
   input  logic [MASK_BITS-1:0] dc_req_data_mask,
   output logic                 dc_resp_valid,
   output logic [DATA_BITS-1:0] dc_resp_data,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   output logic                 mem_req_rw,
   output logic                 mem_req_data_valid,
   input  logic                 mem_req_data_ready,
   output logic [DATA_BITS-1:0] mem_req_data_bits,
   output logic [MASK_BITS-1:0] mem_req_data_mask,
   input  logic                 mem_resp_valid,
   input  logic [DATA_BITS-1:0] mem_resp_data,
   output logic                 spurious_resp
);
   typedef enum logic [1:0] {IDLE, RD_REQ, RD_RESP, WR} state_t;
   state_t state_q, state_d;
   logic gnt_ic_q, gnt_ic_d, prio_ic_q, prio_ic_d;
   logic wr_req_done_q, wr_req_done_d, wr_data_done_q, wr_data_done_d;
   logic spurious_q, spurious_d;
   logic sel_ic, pick_ic, req_v, data_v, req_fire, data_fire, req_done, data_done;
   logic req_rdy, data_rdy, resp_v;
   // dc drives the memory-side payload while idle, so grant=none looks like dc
   assign sel_ic    = (state_q != IDLE) && gnt_ic_q;
   assign pick_ic   = ic_req_valid && (!dc_req_valid || prio_ic_q);
   assign req_v     = sel_ic ? ic_req_valid : dc_req_valid;
   assign data_v    = sel_ic ? ic_req_data_valid : dc_req_data_valid;
   assign req_fire  = mem_req_valid && mem_req_ready;
   assign data_fire = mem_req_data_valid && mem_req_data_ready;
   assign req_done  = wr_req_done_q || req_fire;
   assign data_done = wr_data_done_q || data_fire;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         gnt_ic_q       <= 1'b0;
         prio_ic_q      <= 1'b0;
         wr_req_done_q  <= 1'b0;
         wr_data_done_q <= 1'b0;
         spurious_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_ic_q       <= gnt_ic_d;
         prio_ic_q      <= prio_ic_d;
         wr_req_done_q  <= wr_req_done_d;
         wr_data_done_q <= wr_data_done_d;
         spurious_q     <= spurious_d;
      end
   end
   always_comb begin
      state_d        = state_q;
      gnt_ic_d       = gnt_ic_q;
      prio_ic_d      = prio_ic_q;
      wr_req_done_d  = wr_req_done_q;
      wr_data_done_d = wr_data_done_q;
      spurious_d     = spurious_q || (mem_resp_valid && state_q != RD_RESP);
      case (state_q)
         IDLE: if (ic_req_valid || dc_req_valid) begin
            gnt_ic_d = pick_ic;
            state_d  = (pick_ic ? ic_req_rw : dc_req_rw) ? WR : RD_REQ;
         end
         RD_REQ: if (req_fire) state_d = RD_RESP;
         RD_RESP: if (mem_resp_valid) begin
            state_d   = IDLE;
            prio_ic_d = !gnt_ic_q;
         end
         WR: if (req_done && data_done) begin
            state_d        = IDLE;
            prio_ic_d      = !gnt_ic_q;
            wr_req_done_d  = 1'b0;
            wr_data_done_d = 1'b0;
         end else begin
            wr_req_done_d  = req_done;
            wr_data_done_d = data_done;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      mem_req_valid      = (state_q == RD_REQ && req_v) || (state_q == WR && req_v && !wr_req_done_q);
      mem_req_data_valid = state_q == WR && data_v && !wr_data_done_q;
      req_rdy            = mem_req_ready && (state_q == RD_REQ || (state_q == WR && !wr_req_done_q));
      data_rdy           = mem_req_data_ready && state_q == WR && !wr_data_done_q;
      resp_v             = state_q == RD_RESP && mem_resp_valid;
      ic_req_ready       = sel_ic && req_rdy;
      dc_req_ready       = !sel_ic && req_rdy;
      ic_req_data_ready  = sel_ic && data_rdy;
      dc_req_data_ready  = !sel_ic && data_rdy;
      ic_resp_valid      = sel_ic && resp_v;
      dc_resp_valid      = !sel_ic && resp_v;
   end
   assign mem_req_addr      = sel_ic ? ic_req_addr : dc_req_addr;
   assign mem_req_rw        = sel_ic ? ic_req_rw : dc_req_rw;
   assign mem_req_data_bits = sel_ic ? ic_req_data_bits : dc_req_data_bits;
   assign mem_req_data_mask = sel_ic ? ic_req_data_mask : dc_req_data_mask;
   assign ic_resp_data      = mem_resp_data;
   assign dc_resp_data      = mem_resp_data;
   assign spurious_resp     = spurious_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with memory model and scoreboards for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam logic [DW-1:0] WD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] WD2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
  logic clk = 0, reset_n = 0;
  logic [1:0] v = '0, rw = '0, dv = '0, rdy, drdy, rsv;
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  logic [MW-1:0] m [2];
  logic [DW-1:0] rsd [2];
  logic mem_req_valid, mem_req_rw, mem_req_data_valid, spurious_resp;
  logic mem_req_ready = 1, mem_req_data_ready = 1, mem_resp_valid = 0;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data_bits, mem_resp_data = '0;
  logic [MW-1:0] mem_req_data_mask;
  int errors = 0, checks = 0, cyc = 0, rfires = 0, dfires = 0, spur_n = 0, t0 = 0;
  bit ic_drdy_seen = 0;
  logic [129:0] exp_resp [$];
  logic [28:0] exp_mem [$];
  logic [143:0] exp_wd [$];
  int fire_cyc [$], resp_cyc [$], dfire_cyc [$];
  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(v[1]), .ic_req_ready(rdy[1]), .ic_req_addr(a[1]), .ic_req_rw(rw[1]),
    .ic_req_data_valid(dv[1]), .ic_req_data_ready(drdy[1]), .ic_req_data_bits(d[1]),
    .ic_req_data_mask(m[1]), .ic_resp_valid(rsv[1]), .ic_resp_data(rsd[1]),
    .dc_req_valid(v[0]), .dc_req_ready(rdy[0]), .dc_req_addr(a[0]), .dc_req_rw(rw[0]),
    .dc_req_data_valid(dv[0]), .dc_req_data_ready(drdy[0]), .dc_req_data_bits(d[0]),
    .dc_req_data_mask(m[0]), .dc_resp_valid(rsv[0]), .dc_resp_data(rsd[0]),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .spurious_resp(spurious_resp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [DW-1:0] rdf(input logic [AW-1:0] x);
    return (x == 28'h0000123) ? {16{8'hA5}} : {4{4'h5, x}};
  endfunction
  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask
  initial begin : memory
    bit rf, rst, pend;
    int cnt, seen;
    logic [AW-1:0] ra, pa;
    pend = 0; cnt = 0; seen = 0; pa = '0;
    forever begin
      @(negedge clk);
      rf = mem_req_valid && mem_req_ready && !mem_req_rw;
      ra = mem_req_addr;
      rst = !reset_n;
      @(posedge clk); #2;
      mem_resp_valid = 0;
      if (pend) begin
        if (cnt == 1) begin mem_resp_valid = 1; mem_resp_data = rdf(pa); pend = 0; end
        else cnt--;
      end
      if (rf) begin pend = 1; cnt = 2; pa = ra; end
      if (spur_n != seen) begin mem_resp_valid = 1; mem_resp_data = '1; seen = spur_n; end
      if (rst) begin pend = 0; mem_resp_valid = 0; end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  task automatic cache_req(input int p, input logic w, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    bit rd, dd;
    rd = 0; dd = !w;
    v[p] = 1; rw[p] = w; a[p] = ad; dv[p] = w; d[p] = wd; m[p] = wm;
    for (int i = 0; i < 100 && !(rd && dd); i++) begin
      bit rn, dn;
      @(negedge clk);
      rn = v[p] && rdy[p];
      dn = dv[p] && drdy[p];
      @(posedge clk); #1;
      if (rn) begin v[p] = 0; rd = 1; end
      if (dn) begin dv[p] = 0; dd = 1; end
    end
    chk("handshake", {rd, dd} === 2'b11);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && exp_resp.size() > 0; i++) @(negedge clk);
    chk("drain_resp", exp_resp.size() === 0);
    chk("drain_mem", exp_mem.size() === 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask
  initial begin
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0; m[0] = '0; m[1] = '0;
    fork
      begin : monitor
        logic [129:0] er;
        logic [28:0] em;
        logic [143:0] ew;
        forever begin
          @(negedge clk);
          if (drdy[1]) ic_drdy_seen = 1;
          if (rsv != 2'b00) begin
            resp_cyc.push_back(cyc);
            if (exp_resp.size() == 0) chk("resp_unexpected", rsv === 2'b00);
            else begin
              er = exp_resp.pop_front();
              chk("resp_port", rsv === er[129:128]);
              chk("resp_data", {rsd[1], rsd[0]} === {er[127:0], er[127:0]});
            end
          end
          if (mem_req_valid && mem_req_ready) begin
            rfires++;
            fire_cyc.push_back(cyc);
            if (exp_mem.size() == 0) chk("mem_req_unexpected", exp_mem.size() === 1);
            else begin
              em = exp_mem.pop_front();
              chk("mem_req", {mem_req_rw, mem_req_addr} === em);
            end
          end
          if (mem_req_data_valid && mem_req_data_ready) begin
            dfires++;
            dfire_cyc.push_back(cyc);
            if (exp_wd.size() == 0) chk("mem_wd_unexpected", exp_wd.size() === 1);
            else begin
              ew = exp_wd.pop_front();
              chk("mem_wd", {mem_req_data_mask, mem_req_data_bits} === ew);
            end
          end
        end
      end
    join_none
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {rdy, drdy} === 4'b0000);
    chk("rst_mem_valid", {mem_req_valid, mem_req_data_valid} === 2'b00);
    chk("rst_resp", rsv === 2'b00);
    chk("rst_spur", spurious_resp === 1'b0);
    @(posedge clk); #1;
    reset_n = 1;
    exp_mem.push_back({1'b0, 28'h0000123});
    exp_resp.push_back({2'b01, {16{8'hA5}}});
    fire_cyc.delete();
    t0 = cyc;
    cache_req(0, 1'b0, 28'h0000123, '0, '0);
    chk("t1_ready_latency", fire_cyc[0] - t0 === 1);
    drain();
    do_reset();
    exp_mem.push_back({1'b0, 28'h0000200});
    exp_mem.push_back({1'b0, 28'h0000300});
    exp_resp.push_back({2'b01, rdf(28'h0000200)});
    exp_resp.push_back({2'b10, rdf(28'h0000300)});
    fire_cyc.delete(); resp_cyc.delete();
    fork
      cache_req(0, 1'b0, 28'h0000200, '0, '0);
      cache_req(1, 1'b0, 28'h0000300, '0, '0);
    join
    drain();
    chk("t2_ic_gap", fire_cyc[1] - resp_cyc[0] === 2);
    exp_mem.push_back({1'b0, 28'h0000201});
    exp_mem.push_back({1'b0, 28'h0000301});
    exp_resp.push_back({2'b01, rdf(28'h0000201)});
    exp_resp.push_back({2'b10, rdf(28'h0000301)});
    fork
      cache_req(0, 1'b0, 28'h0000201, '0, '0);
      cache_req(1, 1'b0, 28'h0000301, '0, '0);
    join
    drain();
    mem_req_ready = 0;
    rfires = 0; dfires = 0; ic_drdy_seen = 0;
    fire_cyc.delete(); dfire_cyc.delete();
    exp_mem.push_back({1'b1, 28'h0000040});
    exp_wd.push_back({16'hFFFF, WD1});
    exp_mem.push_back({1'b0, 28'h0000041});
    exp_resp.push_back({2'b01, rdf(28'h0000041)});
    fork
      cache_req(0, 1'b1, 28'h0000040, WD1, 16'hFFFF);
      begin repeat (3) @(posedge clk); #1 mem_req_ready = 1; end
    join
    cache_req(0, 1'b0, 28'h0000041, '0, '0);
    drain();
    chk("t3_req_fires", rfires === 2);
    chk("t3_data_fires", dfires === 1);
    chk("t3_data_lead", fire_cyc[0] - dfire_cyc[0] === 2);
    chk("t3_idle_gap", fire_cyc[1] - fire_cyc[0] === 2);
    chk("t3_ic_data_ready", ic_drdy_seen === 1'b0);
    do_reset();
    resp_cyc.delete();
    exp_mem.push_back({1'b0, 28'h0000100});
    exp_mem.push_back({1'b1, 28'h0000500});
    exp_mem.push_back({1'b0, 28'h0000101});
    exp_mem.push_back({1'b0, 28'h0000102});
    exp_mem.push_back({1'b0, 28'h0000103});
    exp_wd.push_back({16'h00FF, WD2});
    for (int k = 0; k < 4; k++) exp_resp.push_back({2'b10, rdf(AW'(32'h100 + k))});
    fork
      begin for (int k = 0; k < 4; k++) cache_req(1, 1'b0, AW'(32'h100 + k), '0, '0); end
      begin @(posedge clk); #1 cache_req(0, 1'b1, 28'h0000500, WD2, 16'h00FF); end
    join
    drain();
    chk("t4_resp_count", resp_cyc.size() === 4);
    chk("t4_wd_left", exp_wd.size() === 0);
    resp_cyc.delete();
    spur_n++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_spur_set", spurious_resp === 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_spur_sticky", spurious_resp === 1'b1);
    chk("t5_no_resp", resp_cyc.size() === 0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t5_spur_clear", spurious_resp === 1'b0);
    @(posedge clk); #1;
    exp_mem.push_back({1'b0, 28'h0000777});
    cache_req(0, 1'b0, 28'h0000777, '0, '0);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    chk("t6_ready", {rdy, drdy} === 4'b0000);
    chk("t6_mem_valid", {mem_req_valid, mem_req_data_valid} === 2'b00);
    chk("t6_resp", rsv === 2'b00);
    @(posedge clk); #1;
    exp_mem.push_back({1'b0, 28'h0000780});
    exp_mem.push_back({1'b0, 28'h0000781});
    exp_resp.push_back({2'b01, rdf(28'h0000780)});
    exp_resp.push_back({2'b10, rdf(28'h0000781)});
    fork
      cache_req(0, 1'b0, 28'h0000780, '0, '0);
      cache_req(1, 1'b0, 28'h0000781, '0, '0);
    join
    drain();
    chk("final_queues", exp_mem.size() + exp_wd.size() + exp_resp.size() === 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
